// File: rtl/ltc5548_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ltc5548_sys_pkg
// Brief    : Shared register-map constants for the LTC5548 status-pin debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package ltc5548_sys_pkg;

   localparam logic [1:0] ADDR_RAW    = 2'd0;
   localparam logic [1:0] ADDR_TICKS  = 2'd1;
   localparam logic [1:0] ADDR_DB     = 2'd2;
   localparam logic [1:0] ADDR_GLITCH = 2'd3;

   localparam int GLITCH_W = 8;

endpackage
`default_nettype wire

// File: rtl/ltc5548_sys_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : ltc5548_sys_debounce_ch
// Brief    : One pin channel: synchroniser, stability counter and debounced flop.
// Revision : 1.0 - initial release
// ============================================================================
module ltc5548_sys_debounce_ch #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pin,
   input  logic [CNT_W-1:0] ticks,
   input  logic             clr,
   output logic             d,
   output logic             s,
   output logic             glitch
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_d;
   logic                   w_s;
   logic                   w_s_next;
   logic                   w_differ;
   logic                   w_commit;

   assign w_s      = r_sync[SYNC_STAGES-1];
   assign w_s_next = r_sync[SYNC_STAGES-2];
   assign w_differ = (w_s != r_d);
   assign w_commit = w_differ && (r_cnt == ticks - CNT_W'(1));

   // A run of disagreeing samples that ends before commit is a rejected glitch.
   assign glitch = !w_differ && (r_cnt != '0);
   assign d      = r_d;
   assign s      = w_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_d    <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pin};
         if (clr) begin
            r_cnt <= '0;
         end else if (ticks == '0) begin
            // Bypass tracks the value entering the last stage so d equals s.
            r_d   <= w_s_next;
            r_cnt <= '0;
         end else if (!w_differ) begin
            r_cnt <= '0;
         end else if (w_commit) begin
            r_d   <= w_s;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ltc5548_sys_pin_debounce.sv
`default_nettype none
// ============================================================================
// Module   : ltc5548_sys_pin_debounce
// Brief    : Debounced LTC5548 status pins with Avalon-MM period/status registers.
// Revision : 1.0 - initial release
// ============================================================================
module ltc5548_sys_pin_debounce
   import ltc5548_sys_pkg::*;
#(
   parameter int WIDTH         = 2,
   parameter int CNT_W         = 16,
   parameter int DEFAULT_TICKS = 1000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] db_out
);

   logic [CNT_W-1:0]    r_ticks;
   logic [GLITCH_W-1:0] r_glitch_cnt;
   logic [31:0]         r_readdata;
   logic [31:0]         w_rd_next;
   logic [WIDTH-1:0]    w_d;
   logic [WIDTH-1:0]    w_s;
   logic [WIDTH-1:0]    w_glitch;
   logic                w_wr;
   logic                w_clr;
   logic                w_unused;

   assign w_wr     = chipselect && !write_n;
   assign w_clr    = w_wr && (address == ADDR_TICKS);
   assign w_unused = ^writedata[31:CNT_W];

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_ch
         ltc5548_sys_debounce_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
         ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (pin_in[i]),
            .ticks   (r_ticks),
            .clr     (w_clr),
            .d       (w_d[i]),
            .s       (w_s[i]),
            .glitch  (w_glitch[i])
         );
      end
   endgenerate

   always_comb begin
      w_rd_next = '0;
      case (address)
         ADDR_RAW:    w_rd_next[WIDTH-1:0]    = w_s;
         ADDR_TICKS:  w_rd_next[CNT_W-1:0]    = r_ticks;
         ADDR_DB:     w_rd_next[WIDTH-1:0]    = w_d;
         ADDR_GLITCH: w_rd_next[GLITCH_W-1:0] = r_glitch_cnt;
         default:     w_rd_next               = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ticks      <= CNT_W'(DEFAULT_TICKS);
         r_glitch_cnt <= '0;
         r_readdata   <= '0;
      end else begin
         r_readdata <= w_rd_next;
         if (w_clr) begin
            r_ticks <= writedata[CNT_W-1:0];
         end
         // Clearing write wins over a coincident glitch; count saturates.
         if (w_wr && (address == ADDR_GLITCH)) begin
            r_glitch_cnt <= '0;
         end else if ((|w_glitch) && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
         end
      end
   end

   assign readdata = r_readdata;
   assign db_out   = w_d;

endmodule
`default_nettype wire

// File: tb/tb_ltc5548_sys_pin_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltc5548_sys_pin_debounce
// Brief    : Self-checking bench: register table, directed corners, random pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltc5548_sys_pin_debounce;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  pin_in = 2'b00;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [1:0]  db_out;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: synchroniser copies, debounced levels, disagreement run lengths.
   logic [1:0]  m_sy0, m_sy1, m_d;
   int          m_run [2];
   int          m_ticks;
   int          m_gc;
   logic [31:0] m_rd;

   typedef struct {
      bit          cs;
      bit          wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t tbl [13];

   always #5 clk = ~clk;

   ltc5548_sys_pin_debounce #(
      .WIDTH         (2),
      .CNT_W         (16),
      .DEFAULT_TICKS (1000),
      .SYNC_STAGES   (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin_in     (pin_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .db_out     (db_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
   endtask

   task automatic model_reset();
      m_sy0 = 2'b00; m_sy1 = 2'b00; m_d = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_ticks = 1000; m_gc = 0; m_rd = 32'd0;
   endtask

   // A level is accepted once the synchronised pin has disagreed with it for
   // 'ticks' consecutive cycles; a shorter disagreement is a glitch.
   task automatic model_edge();
      logic [1:0] s_old, s_new;
      bit wr, clr, any_g;
      s_old = m_sy1;
      s_new = m_sy0;
      wr    = chipselect && !write_n;
      clr   = wr && (address == 2'd1);
      any_g = 0;
      case (address)
         2'd0:    m_rd = {30'd0, s_old};
         2'd1:    m_rd = 32'(m_ticks);
         2'd2:    m_rd = {30'd0, m_d};
         default: m_rd = 32'(m_gc);
      endcase
      for (int ch = 0; ch < 2; ch++) begin
         if (s_old[ch] == m_d[ch] && m_run[ch] > 0) any_g = 1;
         if (clr) m_run[ch] = 0;
         else if (m_ticks == 0) begin
            m_d[ch] = s_new[ch];
            m_run[ch] = 0;
         end else if (s_old[ch] != m_d[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == m_ticks) begin
               m_d[ch] = s_old[ch];
               m_run[ch] = 0;
            end
         end else m_run[ch] = 0;
      end
      if (wr && address == 2'd3) m_gc = 0;
      else if (any_g && m_gc < 255) m_gc++;
      if (clr) m_ticks = int'(writedata[15:0]);
      m_sy1 = m_sy0;
      m_sy0 = pin_in;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("db_out_vs_model", {30'd0, db_out}, {30'd0, m_d});
      chk("readdata_vs_model", readdata, m_rd);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] data);
      address = a; writedata = data; chipselect = 1'b1; write_n = 1'b0;
      cycle();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] data);
      address = a;
      cycle();
      data = readdata;
   endtask

   initial begin
      logic [31:0] v;
      logic [1:0]  pats [4];
      int n;
      int hold;

      tbl[0]  = '{0, 0, 2'd0, 32'd0,       32'd0};
      tbl[1]  = '{0, 0, 2'd1, 32'd0,       32'd1000};
      tbl[2]  = '{0, 0, 2'd2, 32'd0,       32'd0};
      tbl[3]  = '{0, 0, 2'd3, 32'd0,       32'd0};
      tbl[4]  = '{1, 1, 2'd0, 32'hFFFF,    32'd0};
      tbl[5]  = '{1, 1, 2'd2, 32'hF,       32'd0};
      tbl[6]  = '{0, 0, 2'd1, 32'd0,       32'd1000};
      tbl[7]  = '{1, 1, 2'd1, 32'h12345,   32'd1000};
      tbl[8]  = '{0, 0, 2'd1, 32'd0,       32'h2345};
      tbl[9]  = '{1, 1, 2'd1, 32'd4,       32'h2345};
      tbl[10] = '{0, 0, 2'd1, 32'd0,       32'd4};
      tbl[11] = '{0, 1, 2'd1, 32'd7,       32'd4};
      tbl[12] = '{0, 0, 2'd1, 32'd0,       32'd4};

      // Reset state and register map
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_db_out", {30'd0, db_out}, 32'd0);
      chk("reset_readdata", readdata, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 13; i++) begin
         address = tbl[i].addr; writedata = tbl[i].wdata;
         chipselect = tbl[i].cs; write_n = !tbl[i].wr;
         cycle();
         chk($sformatf("tbl_%0d", i), readdata, tbl[i].exp_rd);
         chipselect = 1'b0; write_n = 1'b1;
      end
      chk("tbl_db_out", {30'd0, db_out}, 32'd0);

      // Accepted edge latency with ticks=4
      pin_in = 2'b01; n = 0;
      while (db_out[0] !== 1'b1 && n < 20) begin cycle(); n++; end
      chk("rise_latency", 32'(n), 32'd6);
      chk("idle_ch1_low", {31'd0, db_out[1]}, 32'd0);

      // Short pulse rejected and counted, then cleared
      pin_in = 2'b11;
      repeat (3) cycle();
      pin_in = 2'b01;
      repeat (6) cycle();
      chk("short_pulse_db1", {31'd0, db_out[1]}, 32'd0);
      rd(2'd3, v); chk("glitch_cnt_one", v, 32'd1);
      wr(2'd3, 32'd0);
      rd(2'd3, v); chk("glitch_cnt_cleared", v, 32'd0);

      // Bypass: two-cycle follow
      wr(2'd1, 32'd0);
      pats[0] = 2'b10; pats[1] = 2'b01; pats[2] = 2'b11; pats[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         pin_in = pats[i];
         cycle();
         cycle();
         chk($sformatf("bypass_%0d", i), {30'd0, db_out}, {30'd0, pats[i]});
      end

      // Glitch counter saturation
      wr(2'd1, 32'd8);
      repeat (300) begin
         pin_in = 2'b01; repeat (3) cycle();
         pin_in = 2'b00; repeat (5) cycle();
      end
      rd(2'd3, v); chk("glitch_saturate", v, 32'd255);

      // Ticks write on the cycle a commit is due
      wr(2'd1, 32'd10);
      pin_in = 2'b01;
      repeat (11) cycle();
      wr(2'd1, 32'd3);
      chk("commit_suppressed", {31'd0, db_out[0]}, 32'd0);
      repeat (2) cycle();
      chk("new_ticks_early", {31'd0, db_out[0]}, 32'd0);
      cycle();
      chk("new_ticks_commit", {31'd0, db_out[0]}, 32'd1);

      // Dual-channel glitch: clear wins, then a dual glitch counts once
      wr(2'd1, 32'd4);
      pin_in = 2'b00; repeat (8) cycle();
      pin_in = 2'b11; repeat (2) cycle();
      pin_in = 2'b00; repeat (2) cycle();
      wr(2'd3, 32'd0);
      rd(2'd3, v); chk("clear_beats_glitch", v, 32'd0);
      pin_in = 2'b11; repeat (2) cycle();
      pin_in = 2'b00; repeat (3) cycle();
      rd(2'd3, v); chk("dual_glitch_once", v, 32'd1);

      // Async reset mid-count, pin held high through reset
      pin_in = 2'b01; repeat (6) cycle();
      pin_in = 2'b00; repeat (4) cycle();
      chk("pre_reset_db0", {31'd0, db_out[0]}, 32'd1);
      pin_in = 2'b01;
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_db", {30'd0, db_out}, 32'd0);
      chk("async_reset_rd", readdata, 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      while (db_out[0] !== 1'b1 && n < 1100) begin cycle(); n++; end
      chk("post_reset_rise", 32'(n), 32'd1002);

      // Randomised traffic against the model
      wr(2'd1, 32'($urandom_range(1, 6)));
      hold = 0;
      repeat (1500) begin
         if (hold == 0) begin
            pin_in = 2'($urandom);
            hold = $urandom_range(1, 9);
         end
         hold--;
         address = 2'($urandom);
         writedata = (address == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
         chipselect = ($urandom_range(0, 15) == 0);
         write_n = 1'($urandom);
         cycle();
      end
      chipselect = 1'b0; write_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
